// File: rtl/square1_pkg.sv
// square1_pkg: shared screen geometry, motion state and colour palette
package square1_pkg;
  localparam int H_ADDR = 640;
  localparam int V_ADDR = 480;
  typedef enum logic {RUN, HOLD} motion_state_t;
  localparam logic [7:0][5:0] PALETTE = {
    6'b101010, 6'b110011, 6'b001111, 6'b111100,
    6'b000011, 6'b001100, 6'b110000, 6'b111111
  };
endpackage

// File: rtl/square_motion.sv
// square_motion: per-frame bouncing position, direction and colour index
module square_motion
  import square1_pkg::*;
#(
  parameter int SIZE = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  input  logic [1:0]  speed,
  input  logic        pause,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic [2:0]  cidx
);
  localparam logic [10:0] XL = 11'(H_ADDR - SIZE);
  localparam logic [10:0] YL = 11'(V_ADDR - SIZE);
  motion_state_t state, state_n;
  logic dx_pos, dy_pos, tick, move, bx, by;
  logic [10:0] step, x_n, y_n;
  // tick on the first blanking line, decide run/hold, then compute the bounced position
  always_comb begin
    tick = hpos == 10'd0 && vpos == 10'(V_ADDR);
    state_n = tick ? (pause ? HOLD : RUN) : state;
    move = tick && state_n == RUN;
    step = 11'(speed) + 11'd1;
    bx = dx_pos ? x + step >= XL : x <= step;
    by = dy_pos ? y + step >= YL : y <= step;
    x_n = bx ? (dx_pos ? XL : 11'd0) : (dx_pos ? x + step : x - step);
    y_n = by ? (dy_pos ? YL : 11'd0) : (dy_pos ? y + step : y - step);
  end
  // state and motion registers; reset wins over any tick in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      x <= 11'((H_ADDR - SIZE) / 2);
      y <= 11'((V_ADDR - SIZE) / 2);
      dx_pos <= 1'b1;
      dy_pos <= 1'b1;
      cidx <= 3'd0;
    end else begin
      state <= state_n;
      if (move) begin
        x <= x_n;
        y <= y_n;
        dx_pos <= dx_pos ^ bx;
        dy_pos <= dy_pos ^ by;
        cidx <= cidx + 3'(bx | by);
      end
    end
  end
endmodule

// File: rtl/square_renderer.sv
// square_renderer: bouncing square hit-test with registered rgb/sync outputs
// Optional background checkerboard enabled by defining SQUARE1_BG_PATTERN_EN.
module square_renderer
  import square1_pkg::*;
#(
  parameter int SIZE = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [1:0] speed,
  input  logic       pause,
  output logic [1:0] r,
  output logic [1:0] g,
  output logic [1:0] b,
  output logic       hsync_o,
  output logic       vsync_o
);
  logic [10:0] x, y;
  logic [2:0] cidx;
  logic hit;
  logic [5:0] rgb_n;
  square_motion #(.SIZE(SIZE)) u_motion (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos),
    .speed(speed), .pause(pause), .x(x), .y(y), .cidx(cidx)
  );
  // square hit-test and pixel colour selection
  always_comb begin
    hit = display_on
      && {1'b0, hpos} >= x && {1'b0, hpos} < x + 11'(SIZE)
      && {1'b0, vpos} >= y && {1'b0, vpos} < y + 11'(SIZE);
`ifdef SQUARE1_BG_PATTERN_EN
    rgb_n = hit ? PALETTE[cidx] : (display_on && (hpos[5] ^ vpos[5])) ? 6'b010001 : 6'd0;
`else
    rgb_n = hit ? PALETTE[cidx] : 6'd0;
`endif
  end
  // colour and syncs share one register stage so they stay aligned
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {r, g, b} <= 6'd0;
      hsync_o <= 1'b1;
      vsync_o <= 1'b1;
    end else begin
      {r, g, b} <= rgb_n;
      hsync_o <= hsync;
      vsync_o <= vsync;
    end
  end
endmodule

// File: doc/square_renderer.md
SQUARE_RENDERER -- requirements
Module: square_renderer

Interface
REQ-001 SHALL have parameter SIZE, default 64, meaning square edge length in pixels (legal 8..128).
REQ-002 SHALL have port clk  input  1  pixel clock, ~25.175/25.2 MHz; one clock; all logic on posedge clk.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port hpos  input  10  horizontal position from the sync generator.
REQ-005 SHALL have port vpos  input  10  vertical position from the sync generator.
REQ-006 SHALL have port display_on  input  1  high inside the 640x480 addressable area.
REQ-007 SHALL have port hsync  input  1  active-low HSync from the sync generator.
REQ-008 SHALL have port vsync  input  1  active-low VSync from the sync generator.
REQ-009 SHALL have port speed  input  2  motion step per frame = speed+1 pixels.
REQ-010 SHALL have port pause  input  1  high freezes motion.
REQ-011 SHALL have port r, g, b  output  2 each  registered colour.
REQ-012 SHALL have port hsync_o, vsync_o  output  1 each  syncs delayed to align with r/g/b.

Function
REQ-013 Output stage SHALL register r, g, b, hsync_o and vsync_o together: exactly 1-cycle latency from inputs.
REQ-014 r/g/b SHALL be 0 whenever display_on=0, regardless of position.
REQ-015 Inside the square (x<=hpos<x+SIZE, y<=vpos<y+SIZE, display_on=1), r/g/b SHALL be palette[cidx].
REQ-016 Elsewhere in the addressable area, r/g/b SHALL be 0 (macro off; see REQ-027).
REQ-017 Frame tick SHALL be asserted for the single cycle with hpos=0 and vpos=480 (first blanking line).
REQ-018 Motion FSM states: RUN and HOLD; RUN->HOLD when pause=1 at tick, HOLD->RUN when pause=0 at tick; position updates only on a tick in RUN (after the transition decision).
REQ-019 Position arithmetic SHALL be 11-bit unsigned; x in [0, 640-SIZE], y in [0, 480-SIZE] always.
REQ-020 Moving positive: if x+step >= 640-SIZE then x<=640-SIZE and dx reverses, else x<=x+step; same for y with 480-SIZE.
REQ-021 Moving negative: if x <= step then x<=0 and dx reverses, else x<=x-step; same for y.
REQ-022 Any bounce on a tick SHALL increment cidx (3-bit, wraps 7->0) by exactly 1, even if X and Y bounce simultaneously (corner).
REQ-023 New x/y/cidx SHALL take effect the cycle after the tick; no change within the addressable area (no tearing).
REQ-024 speed and pause SHALL be sampled only at tick; changes elsewhere have no effect on motion.

Reset
REQ-025 With rst_n=0 at a clock edge: r=g=b=0, hsync_o=vsync_o=1, x=(640-SIZE)/2, y=(480-SIZE)/2, dx=dy=positive, cidx=0, state RUN.
REQ-026 Reset asserted mid-frame or mid-tick SHALL override all updates in that cycle; first output after release reflects the current inputs.

Configuration
REQ-027 Macro SQUARE1_BG_PATTERN_EN: defined -> background pixels outside the square SHALL be {hpos[5]^vpos[5], 0, hpos[5]^vpos[5]} scaled to 2'b01 per channel (dim magenta checkerboard, 32-px cells); undefined -> background black, no pattern logic synthesised.

Structure
REQ-028 Shared package square1_pkg SHALL hold H_ADDR=640, V_ADDR=480, the motion state enum, and the 8-entry 6-bit palette (index 0 = white 2'b11 per channel).
REQ-029 Motion (FSM, x/y/dx/dy/cidx, bounce logic) SHALL be sub-module square_motion; square_renderer holds hit-test and output registers.

Verification
REQ-030 Reset: rst_n=0 two cycles, SIZE=64 -> hsync_o=vsync_o=1, rgb=0, x=288, y=208, cidx=0.
REQ-031 Render: hpos=288, vpos=208, display_on=1 -> next cycle r=g=b=2'b11; hpos=352 -> next cycle rgb=0; hsync=0 in -> hsync_o=0 one cycle later.
REQ-032 Blanking: display_on=0 with hpos/vpos inside square -> rgb=0.
REQ-033 Right bounce: x=574, dx=+, speed=3, tick -> x=576, dx=-, cidx=1; next tick x=572.
REQ-034 Corner: x=575, y=415, dx=dy=+, speed=0, tick -> x=576, y=416, both reverse, cidx advances by exactly 1.
REQ-035 Pause/reset: pause=1 at tick -> x,y unchanged over 3 frames; pause=0 -> moves on next tick; rst_n=0 at tick cycle -> reset values, no update.
